// File: rtl/soc_system_fft_ram_pkg.sv
// Shared defaults and types for the FFT RAM arbiter.
// Holds default widths, the starvation limit and the port-select enum.
package soc_system_fft_ram_pkg;

  localparam int ADDR_W_DEF       = 13;
  localparam int DATA_W_DEF       = 64;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_HOST,
    SEL_ENG
  } sel_e;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v,
    input logic [3:0] lim
  );
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/soc_system_fft_ram_starve_ctr.sv
// Host starvation counter: saturating wait count and forced-grant flag.
// Ports: clk, reset_n, req_i (host requesting), gnt_i (host granted),
//        forced_o (wait count has reached LIMIT).
module soc_system_fft_ram_starve_ctr
  import soc_system_fft_ram_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_i,
  input  logic gnt_i,
  output logic forced_o
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || gnt_i) cnt_d = '0;
    else                 cnt_d = sat_inc(cnt_q, LIM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign forced_o = (cnt_q == LIM);

endmodule

// File: rtl/soc_system_fft_ram_arbiter.sv
// Two-port (host / FFT engine) arbiter onto one single-port RAM.
// Ports: h_* host port, e_* engine port, ram_* RAM side, perf_* counters.
// Engine has priority; host is forced through after STARVE_LIMIT waits.
// Macro FFT_RAM_ARB_PERF_EN compiles in the perf counters (else tied 0).
module soc_system_fft_ram_arbiter
  import soc_system_fft_ram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   h_address,
  input  logic                h_read,
  input  logic                h_write,
  input  logic [DATA_W-1:0]   h_writedata,
  input  logic [DATA_W/8-1:0] h_byteenable,
  output logic                h_waitrequest,
  output logic [DATA_W-1:0]   h_readdata,
  output logic                h_readdatavalid,
  input  logic [ADDR_W-1:0]   e_address,
  input  logic                e_read,
  input  logic                e_write,
  input  logic [DATA_W-1:0]   e_writedata,
  input  logic [DATA_W/8-1:0] e_byteenable,
  output logic                e_waitrequest,
  output logic [DATA_W-1:0]   e_readdata,
  output logic                e_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic [31:0]         perf_h_grants,
  output logic [31:0]         perf_e_grants,
  output logic [31:0]         perf_forced
);

  logic h_req, e_req;
  logic h_forced;
  logic gnt_h, gnt_e;
  sel_e sel;

  logic h_pend_q, h_pend_d;
  logic e_pend_q, e_pend_d;

  assign h_req = h_read | h_write;
  assign e_req = e_read | e_write;

  soc_system_fft_ram_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (h_req),
    .gnt_i    (gnt_h),
    .forced_o (h_forced)
  );

  // Grants are masked while reset is held so both
  // requesters see waitrequest during reset.
  always_comb begin
    sel = SEL_NONE;
    if (!reset_n)
      sel = SEL_NONE;
    else if (h_req && (h_forced || !e_req))
      sel = SEL_HOST;
    else if (e_req)
      sel = SEL_ENG;
  end

  assign gnt_h = (sel == SEL_HOST);
  assign gnt_e = (sel == SEL_ENG);

  assign h_waitrequest = h_req & ~gnt_h;
  assign e_waitrequest = e_req & ~gnt_e;

  // Engine values stay on the RAM bus when idle.
  always_comb begin
    unique case (sel)
      SEL_HOST: begin
        ram_address    = h_address;
        ram_byteenable = h_byteenable;
        ram_writedata  = h_writedata;
      end
      default: begin
        ram_address    = e_address;
        ram_byteenable = e_byteenable;
        ram_writedata  = e_writedata;
      end
    endcase
  end

  assign ram_chipselect = gnt_h | gnt_e;
  assign ram_write      = (gnt_h & h_write) | (gnt_e & e_write);

  // Write wins over read, so a read+write grant is not a read.
  assign h_pend_d = gnt_h & ~h_write;
  assign e_pend_d = gnt_e & ~e_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_pend_q <= 1'b0;
      e_pend_q <= 1'b0;
    end else begin
      h_pend_q <= h_pend_d;
      e_pend_q <= e_pend_d;
    end
  end

  assign h_readdatavalid = h_pend_q;
  assign e_readdatavalid = e_pend_q;
  assign h_readdata      = ram_readdata;
  assign e_readdata      = ram_readdata;

`ifdef FFT_RAM_ARB_PERF_EN
  logic [31:0] ph_q, ph_d;
  logic [31:0] pe_q, pe_d;
  logic [31:0] pf_q, pf_d;

  // A forced grant is one the host only won via starvation.
  always_comb begin
    ph_d = ph_q + {31'd0, gnt_h};
    pe_d = pe_q + {31'd0, gnt_e};
    pf_d = pf_q + {31'd0, gnt_h & e_req & h_forced};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q <= '0;
      pe_q <= '0;
      pf_q <= '0;
    end else begin
      ph_q <= ph_d;
      pe_q <= pe_d;
      pf_q <= pf_d;
    end
  end

  assign perf_h_grants = ph_q;
  assign perf_e_grants = pe_q;
  assign perf_forced   = pf_q;
`else
  assign perf_h_grants = '0;
  assign perf_e_grants = '0;
  assign perf_forced   = '0;
`endif

endmodule

// File: tb/tb_soc_system_fft_ram_arbiter.sv
// Scoreboard bench for soc_system_fft_ram_arbiter.
// Reads push expected data/cycle; a negedge monitor pops on readdatavalid.
module tb_soc_system_fft_ram_arbiter;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int BW = DW / 8;
`ifdef FFT_RAM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] h_address, e_address;
  logic          h_read, h_write, e_read, e_write;
  logic [DW-1:0] h_writedata, e_writedata;
  logic [BW-1:0] h_byteenable, e_byteenable;
  logic          h_waitrequest, e_waitrequest;
  logic [DW-1:0] h_readdata, e_readdata;
  logic          h_readdatavalid, e_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic [DW-1:0] ram_writedata;
  logic          ram_chipselect, ram_write;
  logic [DW-1:0] ram_readdata;
  logic [31:0]   perf_h_grants, perf_e_grants, perf_forced;

  soc_system_fft_ram_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .h_address       (h_address),
    .h_read          (h_read),
    .h_write         (h_write),
    .h_writedata     (h_writedata),
    .h_byteenable    (h_byteenable),
    .h_waitrequest   (h_waitrequest),
    .h_readdata      (h_readdata),
    .h_readdatavalid (h_readdatavalid),
    .e_address       (e_address),
    .e_read          (e_read),
    .e_write         (e_write),
    .e_writedata     (e_writedata),
    .e_byteenable    (e_byteenable),
    .e_waitrequest   (e_waitrequest),
    .e_readdata      (e_readdata),
    .e_readdatavalid (e_readdatavalid),
    .ram_address     (ram_address),
    .ram_byteenable  (ram_byteenable),
    .ram_writedata   (ram_writedata),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_readdata    (ram_readdata),
    .perf_h_grants   (perf_h_grants),
    .perf_e_grants   (perf_e_grants),
    .perf_forced     (perf_forced)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM with one cycle read latency.
  logic [DW-1:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BW; b++)
          if (ram_byteenable[b])
            mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t hq[$];
  exp_t eq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (h_readdatavalid) begin
      if (hq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL h_spurious_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        x = hq.pop_front();
        chk("h_readdata", h_readdata, x.data);
        chk("h_latency", 64'(cyc), 64'(x.cyc));
      end
    end
    if (e_readdatavalid) begin
      if (eq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL e_spurious_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        x = eq.pop_front();
        chk("e_readdata", e_readdata, x.data);
        chk("e_latency", 64'(cyc), 64'(x.cyc));
      end
    end
  end

  // One access on a port; holds it until granted, counts wait cycles.
  task automatic acc(input bit eng, input logic rd, input logic wr,
                     input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [BW-1:0] be, input logic [DW-1:0] exp,
                     output int waits);
    bit g = 0;
    exp_t x;
    waits = 0;
    if (eng) begin
      e_read = rd; e_write = wr; e_address = a;
      e_writedata = wd; e_byteenable = be;
    end else begin
      h_read = rd; h_write = wr; h_address = a;
      h_writedata = wd; h_byteenable = be;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!(eng ? e_waitrequest : h_waitrequest)) begin
        g = 1;
        if (rd && !wr) begin
          x.data = exp;
          x.cyc  = cyc + 1;
          if (eng) eq.push_back(x);
          else     hq.push_back(x);
        end
        break;
      end
      waits++;
    end
    if (!g) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout: port %0d got no grant expected one", eng);
    end
    @(posedge clk);
    #1;
    if (eng) begin e_read = 0; e_write = 0; end
    else     begin h_read = 0; h_write = 0; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wh, we;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    reset_n = 0;
    h_address = '0; e_address = '0;
    h_read = 0; h_write = 0; e_read = 0; e_write = 0;
    h_writedata = '0; e_writedata = '0;
    h_byteenable = '0; e_byteenable = '0;
    idle(2);

    // Reset: grants masked, requesters stalled.
    h_read = 1; e_write = 1;
    @(negedge clk);
    chk("rst_h_wait", h_waitrequest, 1);
    chk("rst_e_wait", e_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_h_rdv", h_readdatavalid, 0);
    chk("rst_perf_h", perf_h_grants, 0);
    chk("rst_perf_f", perf_forced, 0);
    h_read = 0; e_write = 0;
    @(negedge clk);
    chk("idle_h_wait", h_waitrequest, 0);
    chk("idle_e_wait", e_waitrequest, 0);
    @(posedge clk); #1;
    reset_n = 1;
    idle(1);

    // Host-only write then read.
    acc(0, 0, 1, 13'h10, 64'h00000000DEADBEEF, 8'hFF, '0, w);
    chk("t030_wr_wait", w, 0);
    acc(0, 1, 0, 13'h10, '0, 8'hFF, 64'h00000000DEADBEEF, w);
    chk("t030_rd_wait", w, 0);
    idle(2);

    // Read+write together: write wins, low bytes only.
    acc(0, 1, 1, 13'h10, 64'hAAAAAAAA12345678, 8'h0F, '0, w);
    chk("t033_wait", w, 0);
    idle(2);
    acc(0, 1, 0, 13'h10, '0, 8'hFF, 64'h0000000012345678, w);
    idle(2);

    // Preload engine data.
    acc(1, 0, 1, 13'h40, 64'h0123456789ABCDEF, 8'hFF, '0, w);
    for (int i = 0; i < 6; i++)
      acc(1, 0, 1, 13'h100 + 13'(i), {32'hE0E0E0E0, 32'(i)}, 8'hFF, '0, w);
    idle(1);

    // Simultaneous reads: engine first, host next.
    fork
      acc(1, 1, 0, 13'h40, '0, 8'hFF, 64'h0123456789ABCDEF, we);
      acc(0, 1, 0, 13'h10, '0, 8'hFF, 64'h0000000012345678, wh);
    join
    chk("t032_e_wait", we, 0);
    chk("t032_h_wait", wh, 1);
    idle(2);

    // Engine streams reads; host write forced after 4 waits.
    we = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          acc(1, 1, 0, 13'h100 + 13'(i), '0, 8'hFF,
              {32'hE0E0E0E0, 32'(i)}, w);
          we += w;
        end
      end
      acc(0, 0, 1, 13'h20, 64'h5555666677778888, 8'hFF, '0, wh);
    join
    chk("t031_h_wait", wh, 4);
    chk("t031_e_wait", we, 1);
    chk("t031_forced", perf_forced, PERF ? 1 : 0);
    idle(2);
    acc(0, 1, 0, 13'h20, '0, 8'hFF, 64'h5555666677778888, w);
    idle(2);

    // Reset right after a granted engine read drops it.
    e_read = 1; e_address = 13'h40;
    @(negedge clk);
    chk("t034_e_wait", e_waitrequest, 0);
    @(posedge clk); #1;
    reset_n = 0; e_read = 0;
    @(negedge clk);
    chk("t034_e_rdv", e_readdatavalid, 0);
    chk("t034_perf_h", perf_h_grants, 0);
    chk("t034_perf_e", perf_e_grants, 0);
    chk("t034_perf_f", perf_forced, 0);
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    chk("t034_e_rdv_post", e_readdatavalid, 0);
    idle(3);

    // 100 mixed accesses, 50 per port.
    for (int i = 0; i < 100; i++) begin
      unique case (i % 4)
        0: acc(0, 0, 1, 13'h200 + 13'(i), {32'hA5A5A5A5, 32'(i)},
               8'hFF, '0, w);
        1: acc(1, 0, 1, 13'h200 + 13'(i), {32'hA5A5A5A5, 32'(i)},
               8'hFF, '0, w);
        2: acc(0, 1, 0, 13'h200 + 13'(i - 2), '0, 8'hFF,
               {32'hA5A5A5A5, 32'(i - 2)}, w);
        default: acc(1, 1, 0, 13'h200 + 13'(i - 2), '0, 8'hFF,
               {32'hA5A5A5A5, 32'(i - 2)}, w);
      endcase
    end
    chk("t035_perf_h", perf_h_grants, PERF ? 50 : 0);
    chk("t035_perf_e", perf_e_grants, PERF ? 50 : 0);
    chk("t035_sum", 64'(perf_h_grants) + 64'(perf_e_grants),
        PERF ? 100 : 0);
    chk("t035_perf_f", perf_forced, 0);
    idle(3);

    chk("h_queue_empty", hq.size(), 0);
    chk("e_queue_empty", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
